// File: rtl/button_axil_debounce.sv
// Multi-channel debounced push-button peripheral behind an AXI4-Lite slave with a maskable level irq.
// Defining BUTTON_PRESS_CNT_EN adds saturating per-channel press counters at 0x14/0x18.
module button_axil_debounce #(
    parameter int NUM_BUTTONS        = 4,
    parameter int DEBOUNCE_CYCLES    = 1000,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [NUM_BUTTONS-1:0]            btn_in,
    output logic                              irq,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [31:0] ID_VALUE = 32'hB770_0000 | 32'(NUM_BUTTONS);

    logic [NUM_BUTTONS-1:0] state_vec, rise_evt, fall_evt;
    logic [NUM_BUTTONS-1:0] rise_reg, fall_reg, ien_reg, rise_clr, fall_clr;
    logic [1:0]             cfg_reg;
    logic                   irq_reg;
    logic                   awready_reg, bvalid_reg, arready_reg, rvalid_reg;
    logic [31:0]            rdata_reg, rd_mux, wmask, wbits;
    logic                   wr_en, rd_en;
    logic [2:0]             wr_word, rd_word;
    logic                   unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA};

    assign wr_en   = awready_reg & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en   = arready_reg & S_AXI_ARVALID;
    assign wr_word = S_AXI_AWADDR[4:2];
    assign rd_word = S_AXI_ARADDR[4:2];
    assign wmask   = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
    assign wbits   = S_AXI_WDATA & wmask;

    // Per-channel synchroniser, debounce counter and edge detector
    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_ch
        logic          sync1_reg, sync2_reg, state_reg, prev_reg;
        logic [CW-1:0] db_cnt_reg;

        always_ff @(posedge S_AXI_ACLK) begin
            if (S_AXI_ARESET) begin
                sync1_reg  <= 1'b0;
                sync2_reg  <= 1'b0;
                state_reg  <= 1'b0;
                prev_reg   <= 1'b0;
                db_cnt_reg <= '0;
            end else begin
                sync1_reg <= btn_in[gi];
                sync2_reg <= sync1_reg;
                prev_reg  <= state_reg;
                if (sync2_reg == state_reg) begin
                    db_cnt_reg <= '0;
                end else if (db_cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                    state_reg  <= sync2_reg;
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + CW'(1);
                end
            end
        end

        assign state_vec[gi] = state_reg;
        assign rise_evt[gi]  = state_reg & ~prev_reg;
        assign fall_evt[gi]  = ~state_reg & prev_reg;
    end

    assign rise_clr = (wr_en && wr_word == 3'd1) ? wbits[NUM_BUTTONS-1:0] : '0;
    assign fall_clr = (wr_en && wr_word == 3'd2) ? wbits[NUM_BUTTONS-1:0] : '0;

    // Events are OR-ed in after the clear so a coincident W1C never loses one
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rise_reg <= '0;
            fall_reg <= '0;
            ien_reg  <= '0;
            cfg_reg  <= 2'b00;
            irq_reg  <= 1'b0;
        end else begin
            rise_reg <= (rise_reg & ~rise_clr) | rise_evt;
            fall_reg <= (fall_reg & ~fall_clr) | fall_evt;
            if (wr_en && wr_word == 3'd3)
                ien_reg <= (ien_reg & ~wmask[NUM_BUTTONS-1:0]) | wbits[NUM_BUTTONS-1:0];
            if (wr_en && wr_word == 3'd4 && S_AXI_WSTRB[0])
                cfg_reg <= S_AXI_WDATA[1:0];
            irq_reg <= |((rise_reg & ien_reg & {NUM_BUTTONS{cfg_reg[0]}}) |
                         (fall_reg & ien_reg & {NUM_BUTTONS{cfg_reg[1]}}));
        end
    end

`ifdef BUTTON_PRESS_CNT_EN
    logic [4:0]             cnt_sel_reg, sel_new;
    logic [7:0]             cnt_val;
    logic [7:0]             press_cnt [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] cnt_clr;

    // A clear addresses the channel being written in the same beat
    assign sel_new = S_AXI_WSTRB[0] ? S_AXI_WDATA[4:0] : cnt_sel_reg;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET)
            cnt_sel_reg <= '0;
        else if (wr_en && wr_word == 3'd5)
            cnt_sel_reg <= sel_new;
    end

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_cnt
        logic [7:0] cnt_reg;

        assign cnt_clr[gi] = wr_en && wr_word == 3'd5 && S_AXI_WSTRB[3] &&
                             S_AXI_WDATA[31] && sel_new == 5'(gi);

        always_ff @(posedge S_AXI_ACLK) begin
            if (S_AXI_ARESET || cnt_clr[gi])
                cnt_reg <= '0;
            else if (rise_evt[gi] && cnt_reg != 8'hFF)
                cnt_reg <= cnt_reg + 8'd1;
        end

        assign press_cnt[gi] = cnt_reg;
    end

    always_comb begin
        cnt_val = '0;
        for (int i = 0; i < NUM_BUTTONS; i++)
            if (cnt_sel_reg == 5'(i))
                cnt_val = press_cnt[i];
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (rd_word)
            3'd0: rd_mux = 32'(state_vec);
            3'd1: rd_mux = 32'(rise_reg);
            3'd2: rd_mux = 32'(fall_reg);
            3'd3: rd_mux = 32'(ien_reg);
            3'd4: rd_mux = {30'b0, cfg_reg};
`ifdef BUTTON_PRESS_CNT_EN
            3'd5: rd_mux = {27'b0, cnt_sel_reg};
            3'd6: rd_mux = {24'b0, cnt_val};
`endif
            3'd7: rd_mux = ID_VALUE;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            awready_reg <= 1'b0;
            bvalid_reg  <= 1'b0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            awready_reg <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_reg & ~awready_reg;
            if (wr_en)
                bvalid_reg <= 1'b1;
            else if (bvalid_reg && S_AXI_BREADY)
                bvalid_reg <= 1'b0;
            arready_reg <= S_AXI_ARVALID & ~rvalid_reg & ~arready_reg;
            if (rd_en) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_mux;
            end else if (rvalid_reg && S_AXI_RREADY) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign irq           = irq_reg;
    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = awready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_RRESP   = 2'b00;
endmodule

// File: tb/tb_button_axil_debounce.sv
// Bench for button_axil_debounce: window-based debounce model plus AXI handshake model, checked every cycle.
module tb_button_axil_debounce;
    localparam int N  = 4;
    localparam int DC = 8;
`ifdef BUTTON_PRESS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        srst;
    logic [N-1:0] btn, btn_dir, btn_rnd;
    logic        rand_btn;
    logic        irq;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_cmp = 0;
    int n_bad = 0;

    assign btn = rand_btn ? btn_rnd : btn_dir;
    always #5 clk = ~clk;

    button_axil_debounce #(.NUM_BUTTONS(N), .DEBOUNCE_CYCLES(DC),
                           .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(srst), .btn_in(btn), .irq(irq),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 25) $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin samples newest-first; a channel flips once DC consecutive synced samples disagree
    logic [N-1:0] hist [$];
    logic [N-1:0] m_state, m_rise, m_fall, m_ien, m_pend_r, m_pend_f;
    logic [1:0]   m_cfg;
    logic [4:0]   m_sel;
    int           m_cnt [N];
    logic         m_irq, m_awready, m_bvalid, m_arready, m_rvalid;
    logic [31:0]  m_rdata;

    function automatic logic [31:0] m_read(input logic [2:0] w);
        case (w)
            3'd0: return 32'(m_state);
            3'd1: return 32'(m_rise);
            3'd2: return 32'(m_fall);
            3'd3: return 32'(m_ien);
            3'd4: return 32'(m_cfg);
            3'd5: return CNT_EN ? 32'(m_sel) : 32'd0;
            3'd6: return (CNT_EN && m_sel < 5'(N)) ? 32'(m_cnt[m_sel]) : 32'd0;
            default: return 32'hB770_0000 + 32'(N);
        endcase
    endfunction

    task automatic model_step();
        logic [N-1:0] nstate, clr_r, clr_f;
        logic [31:0]  mask, wd, rd;
        logic         we, re, irq_new, aw_new, ar_new, all_diff;
        logic [4:0]   sel_new;
        logic [2:0]   ww;
        if (srst) begin
            hist = {};
            for (int i = 0; i < DC + 2; i++) hist.push_back('0);
            m_state = '0; m_rise = '0; m_fall = '0; m_ien = '0; m_pend_r = '0; m_pend_f = '0;
            m_cfg = '0; m_sel = '0; m_irq = 0; m_awready = 0; m_bvalid = 0;
            m_arready = 0; m_rvalid = 0; m_rdata = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            return;
        end
        we = m_awready && awvalid && wvalid;
        re = m_arready && arvalid;
        ww = awaddr[4:2];
        mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
        wd = wdata & mask;
        rd = m_read(araddr[4:2]);
        irq_new = |((m_rise & m_ien & {N{m_cfg[0]}}) | (m_fall & m_ien & {N{m_cfg[1]}}));
        hist.push_front(btn);
        void'(hist.pop_back());
        nstate = m_state;
        for (int c = 0; c < N; c++) begin
            all_diff = 1'b1;
            for (int j = 2; j < DC + 2; j++) if (hist[j][c] == m_state[c]) all_diff = 1'b0;
            if (all_diff) nstate[c] = ~m_state[c];
        end
        clr_r = (we && ww == 3'd1) ? wd[N-1:0] : '0;
        clr_f = (we && ww == 3'd2) ? wd[N-1:0] : '0;
        sel_new = wstrb[0] ? wdata[4:0] : m_sel;
        for (int i = 0; i < N; i++) begin
            if (CNT_EN && we && ww == 3'd5 && wstrb[3] && wdata[31] && sel_new == 5'(i)) m_cnt[i] = 0;
            else if (m_pend_r[i] && m_cnt[i] < 255) m_cnt[i]++;
        end
        m_rise = (m_rise & ~clr_r) | m_pend_r;
        m_fall = (m_fall & ~clr_f) | m_pend_f;
        m_pend_r = nstate & ~m_state;
        m_pend_f = ~nstate & m_state;
        m_state = nstate;
        if (we && ww == 3'd3) m_ien = (m_ien & ~mask[N-1:0]) | wd[N-1:0];
        if (we && ww == 3'd4 && wstrb[0]) m_cfg = wdata[1:0];
        if (we && ww == 3'd5) m_sel = sel_new;
        aw_new = awvalid && wvalid && !m_bvalid && !m_awready;
        if (we) m_bvalid = 1'b1;
        else if (m_bvalid && bready) m_bvalid = 1'b0;
        m_awready = aw_new;
        ar_new = arvalid && !m_rvalid && !m_arready;
        if (re) begin
            m_rvalid = 1'b1;
            m_rdata = rd;
        end else if (m_rvalid && rready) m_rvalid = 1'b0;
        m_arready = ar_new;
        m_irq = irq_new;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("awready", 32'(awready), 32'(m_awready));
        chk("wready", 32'(wready), 32'(m_awready));
        chk("bvalid", 32'(bvalid), 32'(m_bvalid));
        chk("bresp", 32'(bresp), 32'd0);
        chk("arready", 32'(arready), 32'(m_arready));
        chk("rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("rresp", 32'(rresp), 32'd0);
        chk("irq", 32'(irq), 32'(m_irq));
        if (m_rvalid) chk("rdata", rdata, m_rdata);
    end

    initial begin
        int hold;
        hold = 0;
        btn_rnd = '0;
        forever begin
            @(negedge clk);
            if (hold == 0) begin
                btn_rnd = N'($urandom_range(0, (1 << N) - 1));
                hold = $urandom_range(1, 20);
            end else hold--;
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int bdly, output int bcyc, output logic [1:0] resp);
        int t;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!awready && t < 40);
        chk("aw_handshake", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        t = 0;
        while (!bvalid && t < 40) begin @(negedge clk); t++; end
        chk("b_seen", 32'(bvalid), 32'd1);
        bcyc = 0;
        repeat (bdly) begin
            if (bvalid) bcyc++;
            @(negedge clk);
        end
        if (bvalid) bcyc++;
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        $display("WR addr=%02h data=%08h strb=%h resp=%0d", a, d, s, resp);
    endtask

    task automatic axi_read(input logic [4:0] a, input int rdly, output logic [31:0] d);
        int t;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 40);
        chk("ar_handshake", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 40) begin @(negedge clk); t++; end
        chk("r_seen", 32'(rvalid), 32'd1);
        repeat (rdly) @(negedge clk);
        d = rdata;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        $display("RD addr=%02h data=%08h", a, d);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d, d2;
        logic [1:0]  resp;
        int          bc;
        srst = 1'b1; rand_btn = 1'b0; btn_dir = '0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        repeat (3) @(negedge clk);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        srst = 1'b0;
        repeat (2) @(negedge clk);

        axi_read(5'h1C, 0, d); chk("id", d, 32'hB770_0004);
        axi_read(5'h00, 1, d); chk("state_reset", d, 32'd0);
        axi_read(5'h04, 0, d); chk("rise_reset", d, 32'd0);
        axi_read(5'h08, 2, d); chk("fall_reset", d, 32'd0);

        // pin-to-state latency is 2 + DC cycles
        btn_dir[1] = 1'b1;
        fork
            begin
                repeat (9) @(negedge clk);
                chk("model_latency_before", 32'(m_state[1]), 32'd0);
                @(negedge clk);
                chk("model_latency_after", 32'(m_state[1]), 32'd1);
            end
            begin
                repeat (8) @(negedge clk);
                axi_read(5'h00, 0, d);
                axi_read(5'h00, 0, d2);
            end
        join
        chk("state_before_edge9", d, 32'd0);
        chk("state_after_latency", d2, 32'h2);
        repeat (10) @(negedge clk);
        axi_read(5'h04, 0, d); chk("rise_btn1", d, 32'h2);
        axi_read(5'h08, 0, d); chk("fall_none", d, 32'h0);

        btn_dir[0] = 1'b1;
        repeat (5) @(negedge clk);
        btn_dir[0] = 1'b0;
        repeat (20) @(negedge clk);
        axi_read(5'h00, 0, d); chk("glitch_blocked", d, 32'h2);
        btn_dir[1] = 1'b0;
        repeat (15) @(negedge clk);
        axi_read(5'h08, 0, d); chk("fall_btn1", d, 32'h2);
        axi_write(5'h04, 32'hF, 4'hF, 0, bc, resp);
        axi_write(5'h08, 32'hF, 4'hF, 1, bc, resp);

        axi_write(5'h0C, 32'h2, 4'hF, 0, bc, resp);
        axi_write(5'h10, 32'h1, 4'hF, 0, bc, resp);
        btn_dir[1] = 1'b1;
        repeat (15) @(negedge clk);
        chk("irq_on_rise", 32'(irq), 32'd1);
        axi_write(5'h04, 32'h2, 4'hF, 0, bc, resp);
        chk("irq_after_w1c", 32'(irq), 32'd0);
        btn_dir[1] = 1'b0;
        repeat (15) @(negedge clk);
        chk("irq_fall_disabled", 32'(irq), 32'd0);

        // W1C handshake lands on the same edge RISE[2] is set
        btn_dir[2] = 1'b1;
        repeat (9) @(negedge clk);
        axi_write(5'h04, 32'h4, 4'hF, 5, bc, resp);
        chk("bvalid_held_cycles", 32'(bc), 32'd6);
        chk("single_b", 32'(bvalid), 32'd0);
        axi_read(5'h04, 0, d); chk("w1c_set_wins", d & 32'h4, 32'h4);

        axi_write(5'h0C, 32'h0000_FFFF, 4'h1, 0, bc, resp);
        axi_read(5'h0C, 0, d); chk("ien_strobe", d, 32'h0000_000F);
        axi_write(5'h1C, 32'h1234_5678, 4'hF, 0, bc, resp);
        chk("id_write_resp", 32'(resp), 32'd0);
        axi_read(5'h1C, 0, d); chk("id_unchanged", d, 32'hB770_0004);

        // reset while a read response is pending
        araddr = 5'h1C; arvalid = 1'b1; rready = 1'b0;
        repeat (4) @(negedge clk);
        srst = 1'b1; arvalid = 1'b0;
        @(negedge clk);
        srst = 1'b0;
        chk("reset_drops_rvalid", 32'(rvalid), 32'd0);
        chk("reset_clears_rdata", rdata, 32'd0);
        btn_dir = '0;
        repeat (15) @(negedge clk);
        axi_read(5'h0C, 0, d); chk("ien_after_reset", d, 32'd0);

`ifdef BUTTON_PRESS_CNT_EN
        for (int p = 0; p < 300; p++) begin
            btn_dir[3] = 1'b1;
            repeat (12) @(negedge clk);
            btn_dir[3] = 1'b0;
            repeat (12) @(negedge clk);
        end
        axi_write(5'h14, 32'h3, 4'hF, 0, bc, resp);
        axi_read(5'h18, 0, d); chk("cnt_saturated", d, 32'd255);
        axi_write(5'h14, 32'h8000_0003, 4'hF, 0, bc, resp);
        axi_read(5'h18, 0, d); chk("cnt_cleared", d, 32'd0);
        axi_read(5'h14, 0, d); chk("cnt_sel_bit31", d, 32'd3);
`else
        btn_dir[3] = 1'b1;
        repeat (15) @(negedge clk);
        btn_dir[3] = 1'b0;
        axi_write(5'h14, 32'h3, 4'hF, 0, bc, resp);
        axi_read(5'h14, 0, d); chk("cnt_sel_absent", d, 32'd0);
        axi_read(5'h18, 0, d); chk("cnt_val_absent", d, 32'd0);
`endif

        rand_btn = 1'b1;
        for (int it = 0; it < 160; it++) begin
            case ($urandom_range(0, 3))
                0: axi_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                             $urandom_range(0, 3), bc, resp);
                1: axi_read(5'($urandom_range(0, 31)), $urandom_range(0, 3), d);
                2: fork
                       axi_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                                 $urandom_range(0, 2), bc, resp);
                       axi_read(5'($urandom_range(0, 31)), $urandom_range(0, 2), d);
                   join
                default: repeat ($urandom_range(1, 12)) @(negedge clk);
            endcase
        end
        rand_btn = 1'b0;
        btn_dir = '0;
        repeat (30) @(negedge clk);
        axi_read(5'h00, 0, d); chk("state_idle_end", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
